// File: rtl/pmem_arbiter.sv
// Shares one line-granular physical-memory port between the I-cache and D-cache.
// Define PMEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the D-cache wins ties.
module pmem_arbiter #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wdata_q;
    logic                    write_q;
    logic                    last_d_q;

    logic i_pend_c;
    logic d_pend_c;
    logic tie_d_c;
    logic grant_d_c;
    logic grant_i_c;

    assign i_pend_c = i_read;
    assign d_pend_c = d_read | d_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    assign tie_d_c = ~last_d_q;
`else
    // D always wins a tie; last_d_q is tracked but has no influence here.
    assign tie_d_c = last_d_q | 1'b1;
`endif

    assign grant_d_c = d_pend_c & (~i_pend_c | tie_d_c);
    assign grant_i_c = i_pend_c & ~grant_d_c;

    // Arbitration FSM with latched transaction fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            last_d_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d_c) begin
                        state_q  <= SERVE_D;
                        addr_q   <= d_address;
                        wdata_q  <= d_wdata;
                        write_q  <= d_write;
                        last_d_q <= 1'b1;
                    end else if (grant_i_c) begin
                        state_q  <= SERVE_I;
                        addr_q   <= i_address;
                        write_q  <= 1'b0;
                        last_d_q <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state_q <= RELEASE;
                    end
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes decode registered state only, so live requester inputs cannot disturb them.
    assign pmem_read    = (state_q == SERVE_I) | ((state_q == SERVE_D) & ~write_q);
    assign pmem_write   = (state_q == SERVE_D) & write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_resp  = (state_q == SERVE_I) & pmem_resp;
    assign d_resp  = (state_q == SERVE_D) & pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: cycle table plus reset and tie-arbitration sequences.
module tb_pmem_arbiter;

    logic         clk;
    logic         rst_n;
    logic         i_read;
    logic [31:0]  i_address;
    logic         i_resp;
    logic [255:0] i_rdata;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic         d_resp;
    logic [255:0] d_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;

    int checks = 0;
    int errors = 0;

    pmem_arbiter #(.LINE_WIDTH(256), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         i_rd;
        logic [31:0]  i_ad;
        logic         d_rd;
        logic         d_wr;
        logic [31:0]  d_ad;
        logic [255:0] d_wd;
        logic         p_resp;
        logic [255:0] p_rd;
        logic         e_rd;
        logic         e_wr;
        logic [31:0]  e_ad;
        logic [255:0] e_wd;
        logic         e_ir;
        logic         e_dr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic i_rd, logic [31:0] i_ad, logic d_rd, logic d_wr,
                                logic [31:0] d_ad, logic [255:0] d_wd, logic p_resp,
                                logic [255:0] p_rd, logic e_rd, logic e_wr,
                                logic [31:0] e_ad, logic [255:0] e_wd, logic e_ir, logic e_dr);
        vec_t v;
        v.i_rd = i_rd; v.i_ad = i_ad; v.d_rd = d_rd; v.d_wr = d_wr;
        v.d_ad = d_ad; v.d_wd = d_wd; v.p_resp = p_resp; v.p_rd = p_rd;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_ad = e_ad; v.e_wd = e_wd;
        v.e_ir = e_ir; v.e_dr = e_dr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
    endtask

    localparam logic [255:0] LA5 = {32{8'hA5}};
    localparam logic [255:0] W1  = {8{32'h1234_5678}};
    localparam logic [255:0] W2  = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] W3  = {8{32'h0BAD_F00D}};
    localparam logic [31:0]  IA  = 32'h0000_1000;
    localparam logic [31:0]  DA  = 32'h8000_0040;
    localparam logic [31:0]  DB  = 32'hFFFF_FFC0;
    localparam logic [31:0]  SA  = 32'h0000_0200;
    localparam logic [31:0]  XA  = 32'h0000_0300;

    initial begin
        int  ntr;
        int  str_cnt;
        int  idle_cnt;
        bit  done;
        bit  drop_d;
        bit  side_d;
        bit  got[3];
        int  gaps[3];
        bit  exp_got[3];

        // lone I read
        vecs.push_back(mk(1, IA, 0, 0, 0, 0, 0, 0,    0, 0, 0,  0,  0, 0));
        vecs.push_back(mk(1, IA, 0, 0, 0, 0, 0, 0,    1, 0, IA, 0,  0, 0));
        vecs.push_back(mk(1, IA, 0, 0, 0, 0, 0, 0,    1, 0, IA, 0,  0, 0));
        vecs.push_back(mk(1, IA, 0, 0, 0, 0, 0, 0,    1, 0, IA, 0,  0, 0));
        vecs.push_back(mk(1, IA, 0, 0, 0, 0, 1, LA5,  1, 0, IA, 0,  1, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0,    0, 0, IA, 0,  0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0,    0, 0, IA, 0,  0, 0));
        // D write-back with address/data changing mid-transaction
        vecs.push_back(mk(0, 0, 0, 1, DA, W1, 0, 0,   0, 0, IA, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 1, DA, W1, 0, 0,   0, 1, DA, W1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, DB, W3, 0, 0,   0, 1, DA, W1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, DB, W3, 1, LA5, 0, 1, DA, W1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0, 0,   0, 0, DA, W1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0, 0,   0, 0, DA, W1, 0, 0));
        // read+write together: write wins
        vecs.push_back(mk(0, 0, 1, 1, SA, W2, 0, 0,   0, 0, DA, W1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, SA, W2, 0, 0,   0, 1, SA, W2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, SA, W2, 1, 0,   0, 1, SA, W2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0, 0,   0, 0, SA, W2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0, 0,   0, 0, SA, W2, 0, 0));
        // spurious resp in IDLE
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  1, LA5, 0, 0, SA, W2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0, 0,   0, 0, SA, W2, 0, 0));
        // D read with a two-cycle resp
        vecs.push_back(mk(0, 0, 1, 0, XA, 0,  0, 0,   0, 0, SA, W2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, XA, 0,  0, 0,   1, 0, XA, 0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 0, XA, 0,  1, W2,  1, 0, XA, 0,  0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  1, W2,  0, 0, XA, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0, 0,   0, 0, XA, 0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0, 0,   0, 0, XA, 0,  0, 0));

        rst_n = 1'b0;
        drive_idle();
        #1;
        chk("rst_pmem_read",  256'(pmem_read),    256'(0));
        chk("rst_pmem_write", 256'(pmem_write),   256'(0));
        chk("rst_pmem_addr",  256'(pmem_address), 256'(0));
        chk("rst_pmem_wdata", pmem_wdata,         256'(0));
        chk("rst_i_resp",     256'(i_resp),       256'(0));
        chk("rst_d_resp",     256'(d_resp),       256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            i_read = vecs[k].i_rd; i_address = vecs[k].i_ad;
            d_read = vecs[k].d_rd; d_write = vecs[k].d_wr;
            d_address = vecs[k].d_ad; d_wdata = vecs[k].d_wd;
            pmem_resp = vecs[k].p_resp; pmem_rdata = vecs[k].p_rd;
            #1;
            chk($sformatf("v%0d_pmem_read", k),  256'(pmem_read),    256'(vecs[k].e_rd));
            chk($sformatf("v%0d_pmem_write", k), 256'(pmem_write),   256'(vecs[k].e_wr));
            chk($sformatf("v%0d_pmem_addr", k),  256'(pmem_address), 256'(vecs[k].e_ad));
            chk($sformatf("v%0d_pmem_wdata", k), pmem_wdata,         vecs[k].e_wd);
            chk($sformatf("v%0d_i_resp", k),     256'(i_resp),       256'(vecs[k].e_ir));
            chk($sformatf("v%0d_d_resp", k),     256'(d_resp),       256'(vecs[k].e_dr));
            if (vecs[k].e_ir) chk($sformatf("v%0d_i_rdata", k), i_rdata, vecs[k].p_rd);
            if (vecs[k].e_dr) chk($sformatf("v%0d_d_rdata", k), d_rdata, vecs[k].p_rd);
        end

        // reset two cycles into an I read
        @(negedge clk);
        i_read = 1'b1; i_address = 32'h0000_0600;
        @(negedge clk); #1;
        chk("mr_read_rise", 256'(pmem_read),    256'(1));
        chk("mr_addr",      256'(pmem_address), 256'(32'h0000_0600));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; pmem_resp = 1'b1; pmem_rdata = LA5;
        #1;
        chk("mr_read_async", 256'(pmem_read),    256'(0));
        chk("mr_i_resp",     256'(i_resp),       256'(0));
        chk("mr_d_resp",     256'(d_resp),       256'(0));
        chk("mr_addr_clr",   256'(pmem_address), 256'(0));
        i_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; pmem_resp = 1'b0;
        #1;
        chk("mr_idle_read", 256'(pmem_read), 256'(0));
        @(negedge clk);
        i_read = 1'b1; i_address = 32'h0000_0700;
        #1;
        chk("pr_no_strobe", 256'(pmem_read), 256'(0));
        @(negedge clk); #1;
        chk("pr_read",  256'(pmem_read),    256'(1));
        chk("pr_addr",  256'(pmem_address), 256'(32'h0000_0700));
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = W2;
        #1;
        chk("pr_i_resp",  256'(i_resp), 256'(1));
        chk("pr_i_rdata", i_rdata,      W2);
        @(negedge clk);
        pmem_resp = 1'b0; i_read = 1'b0;
        #1;
        chk("pr_release", 256'(pmem_read), 256'(0));
        @(negedge clk);

        // simultaneous requests held high
        i_read = 1'b1; d_read = 1'b1;
        i_address = 32'h0000_0400; d_address = 32'h0000_0500;
        ntr = 0; str_cnt = 0; idle_cnt = 0; done = 0; drop_d = 0; side_d = 0;
        got[0] = 0; got[1] = 0; got[2] = 0;
        gaps[0] = 0; gaps[1] = 0; gaps[2] = 0;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (drop_d) d_read = 1'b0;
            pmem_resp = (str_cnt == 1);
            #1;
            if (pmem_read | pmem_write) begin
                if (str_cnt == 0) begin
                    side_d = (pmem_address == 32'h0000_0500);
                    if (ntr < 3) begin
                        got[ntr] = side_d;
                        gaps[ntr] = idle_cnt;
                    end
                    ntr++;
                end
                str_cnt++;
                idle_cnt = 0;
                if (pmem_resp) begin
                    chk($sformatf("sim%0d_d_resp", ntr), 256'(d_resp), 256'(side_d));
                    chk($sformatf("sim%0d_i_resp", ntr), 256'(i_resp), 256'(!side_d));
`ifndef PMEM_ARB_ROUND_ROBIN_EN
                    if (side_d) drop_d = 1;
`endif
                    if (ntr == 3) done = 1;
                end
            end else begin
                str_cnt = 0;
                idle_cnt++;
            end
        end
        @(negedge clk);
        drive_idle();

`ifdef PMEM_ARB_ROUND_ROBIN_EN
        exp_got[0] = 1; exp_got[1] = 0; exp_got[2] = 1;
`else
        exp_got[0] = 1; exp_got[1] = 0; exp_got[2] = 0;
`endif
        chk("sim_trans_count", 256'(ntr), 256'(3));
        for (int k = 0; k < 3; k++)
            chk($sformatf("sim_grant%0d_is_d", k), 256'(got[k]), 256'(exp_got[k]));
        chk("sim_gap1", 256'(gaps[1]), 256'(2));
        chk("sim_gap2", 256'(gaps[2]), 256'(2));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-port physical-memory arbiter that shares the single 256-bit line-granular physical-memory port between the instruction cache and the data cache. It sits between both cache controllers and main memory/L2. It latches the winning request, drives one physical-memory transaction at a time, and routes the response back to the requester that issued it. The block is sequential: a 4-state FSM plus registered address, data and grant state.

## Interface
- `LINE_WIDTH`, default 256: width of a cache line in bits.
- `ADDR_WIDTH`, default 32: width of physical addresses.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_read`  in  1  I-cache line-fill request.
- `i_address`  in  ADDR_WIDTH  I-cache line address.
- `i_resp`  out  1  I-cache transaction complete.
- `i_rdata`  out  LINE_WIDTH  fill data to the I-cache.
- `d_read`  in  1  D-cache line-fill request.
- `d_write`  in  1  D-cache write-back request.
- `d_address`  in  ADDR_WIDTH  D-cache line address.
- `d_wdata`  in  LINE_WIDTH  write-back line.
- `d_resp`  out  1  D-cache transaction complete.
- `d_rdata`  out  LINE_WIDTH  fill data to the D-cache.
- `pmem_read`  out  1  physical-memory read strobe.
- `pmem_write`  out  1  physical-memory write strobe.
- `pmem_address`  out  ADDR_WIDTH  physical-memory address.
- `pmem_wdata`  out  LINE_WIDTH  physical-memory write line.
- `pmem_resp`  in  1  physical-memory transaction done.
- `pmem_rdata`  in  LINE_WIDTH  physical-memory read line.

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D, RELEASE.
- **IDLE**
  - I pending = `i_read`; D pending = `d_read | d_write`.
  - On a grant: latch address, op (read/write) and `d_wdata` into registers; update `last_grant`.
  - Transitions: to SERVE_I or SERVE_D per the arbitration rule (Configuration); stay in IDLE if nothing is pending.
- **D-side op select:** if `d_read` and `d_write` are both high, the write is performed. The read is served as a later, separate transaction after the D-cache deasserts `d_write`.
- **SERVE_x**
  - `pmem_read`/`pmem_write`, `pmem_address` and `pmem_wdata` are driven from the latched registers, not from live inputs. Requester inputs changing mid-transaction have no effect.
  - `pmem_resp` is forwarded combinationally: `x_resp = pmem_resp` while in SERVE_x, and `x_rdata = pmem_rdata`.
  - On `pmem_resp`, go to RELEASE.
- **RELEASE:** no strobes asserted; unconditionally go to IDLE. This gives the requester one cycle to drop its request, so a stale request is never re-granted.
- **Idle outputs:**
  - `i_resp` and `d_resp` are 0 outside their SERVE state.
  - `pmem_resp` arriving in IDLE or RELEASE is ignored.
  - `i_rdata`/`d_rdata` are always `pmem_rdata`; they are meaningful only while the matching resp is high.
- **Reset (asynchronous, `rst_n` = 0):**
  - State = IDLE; all strobes and resps = 0.
  - `pmem_address` = 0 and `pmem_wdata` = 0.
  - `last_grant` = I, so the first tie goes to D under round-robin.
  - Reset mid-transaction aborts immediately, with no response to the requester.

## Timing
- Request seen high in IDLE at edge N: pmem strobe high from cycle N+1.
- `pmem_resp` high in cycle K: `x_resp` is high in cycle K (0-cycle added response latency). The strobe drops in K+1 (RELEASE). IDLE is reached in K+2, and the earliest next strobe is in K+3.
- Arbitration overhead: 1 cycle before the transaction and 2 cycles after it.
- Strobes are registered-state decodes, glitch-free. Exactly one of `pmem_read`/`pmem_write` is high in SERVE_x; both are 0 elsewhere.
- `pmem_resp` held high for more than one cycle: only the first cycle is honoured, because the FSM has already left SERVE.

## Configuration
- Macro: `PMEM_ARB_ROUND_ROBIN_EN`.
- **Defined:** simultaneous I and D requests in IDLE grant the side opposite `last_grant`. A lone request is granted regardless of `last_grant`.
- **Undefined:** fixed priority, D always wins ties. `last_grant` is still maintained but unused.

## Test plan
- **Lone I read:** `i_read`, `i_address` = 0x0000_1000; pmem responds 3 cycles after the strobe with line 0xA5…A5.
  - Required: `pmem_read` high the cycle after the request.
  - Required: `pmem_address` = 0x0000_1000.
  - Required: `i_resp` = 1 in the same cycle as `pmem_resp`, with `i_rdata` = 0xA5…A5.
  - Required: `d_resp` stays 0.
- **D write-back:** `d_write`, `d_address` = 0x8000_0040, `d_wdata` = 0x1234…; the D-cache changes `d_address` to 0xFFFF_FFC0 mid-transaction.
  - Required: `pmem_write` = 1 throughout.
  - Required: `pmem_address` stays 0x8000_0040; `pmem_wdata` stays 0x1234….
  - Required: `d_resp` = 1 on `pmem_resp`.
- **Simultaneous requests, held high:** `i_read` and `d_read` both held high.
  - With the macro: grants alternate D, I, D.
  - Without the macro: D is served first. If D then drops its request, I is served next.
  - In both builds, strobes in consecutive transactions are separated by exactly 2 idle strobe cycles.
- **Write precedence:** `d_read` and `d_write` both high → `pmem_write` is performed, not `pmem_read`.
- **Spurious/extended resp:** `pmem_resp` high in IDLE → no resp output and no state change. `pmem_resp` held high for 2 cycles in SERVE_D → `d_resp` pulses exactly 1 cycle.
- **Reset mid-transaction:** `rst_n` low 2 cycles after `pmem_read` rises.
  - Required: `pmem_read` = 0 immediately (asynchronously), and no resp is issued.
  - After release, a new request is granted normally.
